// File: rtl/caster_pwr_pkg.sv
// Shared power-sequencing definitions: state encodings, default timing
// constants and the per-state output decode. Also used by the PMIC
// controller debug decode, so encodings must stay stable.
package caster_pwr_pkg;

    localparam int unsigned CNT_W = 24;

    localparam logic [CNT_W-1:0] DEF_PON_TIMEOUT  = 24'd8000000;
    localparam logic [CNT_W-1:0] DEF_VCOM_SETTLE  = 24'd330000;
    localparam logic [CNT_W-1:0] DEF_VCOM_OFF_DLY = 24'd330000;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RAIL_UP   = 3'd1,
        ST_VCOM_UP   = 3'd2,
        ST_ON        = 3'd3,
        ST_VCOM_DOWN = 3'd4,
        ST_FAULT     = 3'd5
    } pwr_state_t;

    typedef struct packed {
        logic en;
        logic cen;
        logic ready;
        logic fault;
    } pwr_out_t;

    function automatic pwr_out_t state_outputs(input pwr_state_t s);
        pwr_out_t o;
        o = '0;
        case (s)
            ST_RAIL_UP:   o.en = 1'b1;
            ST_VCOM_UP:   begin o.en = 1'b1; o.cen = 1'b1; end
            ST_ON:        begin o.en = 1'b1; o.cen = 1'b1; o.ready = 1'b1; end
            ST_VCOM_DOWN: o.en = 1'b1;
            ST_FAULT:     o.fault = 1'b1;
            default:      o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/power_seq.sv
// Panel power sequencer: brings up PMIC main rails, then VCOM, reports
// ready once settled, and walks back down in reverse order. Any PMIC link
// error, power-good loss while on, or power-up timeout latches FAULT until
// reset. All outputs are registered from the next-state decode.
module power_seq
    import caster_pwr_pkg::*;
#(
    parameter logic [23:0] PON_TIMEOUT  = DEF_PON_TIMEOUT,
    parameter logic [23:0] VCOM_SETTLE  = DEF_VCOM_SETTLE,
    parameter logic [23:0] VCOM_OFF_DLY = DEF_VCOM_OFF_DLY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sys_req,
    output logic       sys_ready,
    output logic       sys_fault,
    output logic       pwr_en,
    output logic       pwr_cen,
    input  logic       pwr_pok,
    input  logic       pwr_error,
    output logic [2:0] dbg_state
);

    localparam logic [23:0] PON_LAST    = PON_TIMEOUT - 24'd1;
    localparam logic [23:0] SETTLE_LAST = VCOM_SETTLE - 24'd1;
    localparam logic [23:0] OFF_LAST    = VCOM_OFF_DLY - 24'd1;

    pwr_state_t  state, state_next;
    logic [23:0] cnt, cnt_next;
    pwr_out_t    out_next;

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            cnt       <= '0;
            pwr_en    <= 1'b0;
            pwr_cen   <= 1'b0;
            sys_ready <= 1'b0;
            sys_fault <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pwr_en    <= out_next.en;
            pwr_cen   <= out_next.cen;
            sys_ready <= out_next.ready;
            sys_fault <= out_next.fault;
        end
    end

    // Next-state and counter decode; counter restarts on every state change
    always_comb begin
        state_next = state;
        if (pwr_error) begin
            state_next = ST_FAULT;
        end else begin
            case (state)
                ST_OFF:
                    if (sys_req) state_next = ST_RAIL_UP;
                ST_RAIL_UP:
                    if (!sys_req)             state_next = ST_VCOM_DOWN;
                    else if (pwr_pok)         state_next = ST_VCOM_UP;
                    else if (cnt >= PON_LAST) state_next = ST_FAULT;
                ST_VCOM_UP:
                    if (!sys_req)                state_next = ST_VCOM_DOWN;
                    else if (cnt >= SETTLE_LAST) state_next = ST_ON;
                ST_ON:
                    if (!pwr_pok)      state_next = ST_FAULT;
                    else if (!sys_req) state_next = ST_VCOM_DOWN;
                ST_VCOM_DOWN:
                    if (cnt >= OFF_LAST) state_next = ST_OFF;
                ST_FAULT:
                    state_next = ST_FAULT;
                default:
                    state_next = ST_FAULT;
            endcase
        end

        if (state_next != state) cnt_next = '0;
        else if (cnt != '1)      cnt_next = cnt + 24'd1;
        else                     cnt_next = cnt;
    end

    // Output decode from the upcoming state so the registered outputs
    // change on the same edge as the state itself
    always_comb begin
        out_next = state_outputs(state_next);
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_power_seq.sv
// Directed and randomized bench for power_seq against a phase/countdown
// reference model written from the sequencing rules.
module tb_power_seq;

    localparam int PON_N = 100;
    localparam int SET_N = 10;
    localparam int OFF_N = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sys_req = 1'b0;
    logic       pwr_pok = 1'b0;
    logic       pwr_error = 1'b0;
    logic       sys_ready, sys_fault, pwr_en, pwr_cen;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;

    // reference model: phase number and cycles remaining in the timed phase
    int m_phase = 0;
    int m_left  = 0;

    power_seq #(
        .PON_TIMEOUT (24'd100),
        .VCOM_SETTLE (24'd10),
        .VCOM_OFF_DLY(24'd10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sys_req  (sys_req),
        .sys_ready(sys_ready),
        .sys_fault(sys_fault),
        .pwr_en   (pwr_en),
        .pwr_cen  (pwr_cen),
        .pwr_pok  (pwr_pok),
        .pwr_error(pwr_error),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock edge of the rules: 0 off, 1 rails, 2 vcom, 3 on, 4 vcom down, 5 fault
    task automatic model_step();
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
        end else if (pwr_error) begin
            m_phase = 5;
        end else begin
            case (m_phase)
                0: if (sys_req) begin m_phase = 1; m_left = PON_N; end
                1: begin
                    if (!sys_req) begin m_phase = 4; m_left = OFF_N; end
                    else if (pwr_pok) begin m_phase = 2; m_left = SET_N; end
                    else begin
                        m_left--;
                        if (m_left == 0) m_phase = 5;
                    end
                end
                2: begin
                    if (!sys_req) begin m_phase = 4; m_left = OFF_N; end
                    else begin
                        m_left--;
                        if (m_left == 0) m_phase = 3;
                    end
                end
                3: begin
                    if (!pwr_pok) m_phase = 5;
                    else if (!sys_req) begin m_phase = 4; m_left = OFF_N; end
                end
                4: begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
                default: m_phase = 5;
            endcase
        end
    endtask

    function automatic logic [6:0] expect_vec();
        logic en, cen, rdy, flt;
        logic [31:0] ph;
        en  = (m_phase >= 1 && m_phase <= 4);
        cen = (m_phase == 2 || m_phase == 3);
        rdy = (m_phase == 3);
        flt = (m_phase == 5);
        ph  = m_phase;
        return {en, cen, rdy, flt, ph[2:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("outputs", {25'b0, pwr_en, pwr_cen, sys_ready, sys_fault, dbg_state},
              {25'b0, expect_vec()});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sys_req = 1'b0; pwr_pok = 1'b0; pwr_error = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic go_on();
        sys_req = 1'b1;
        pwr_pok = 1'b1;
        for (int i = 0; i < 20 && m_phase != 3; i++) tick();
        check("reach_on", 32'(dbg_state), 32'd3);
    endtask

    initial begin
        int n;

        // reset state
        do_reset();
        check("reset_en", 32'(pwr_en), 32'd0);
        check("reset_fault", 32'(sys_fault), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        // power-up: pok after 40 rail cycles, ready 10 cycles after cen
        sys_req = 1'b1;
        tick();
        check("en_after_req", 32'(pwr_en), 32'd1);
        check("cen_before_pok", 32'(pwr_cen), 32'd0);
        repeat (39) tick();
        pwr_pok = 1'b1;
        tick();
        check("cen_after_pok", 32'(pwr_cen), 32'd1);
        n = 0;
        while (!sys_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_latency", 32'(n), 32'd10);

        // power-down with re-request mid-delay
        sys_req = 1'b0;
        tick();
        check("down_cen", 32'(pwr_cen), 32'd0);
        check("down_ready", 32'(sys_ready), 32'd0);
        check("down_en", 32'(pwr_en), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) sys_req = 1'b1;
            tick();
            if (i == 9) check("down_en_held", 32'(pwr_en), 32'd1);
        end
        check("down_off_en", 32'(pwr_en), 32'd0);
        check("down_off_state", 32'(dbg_state), 32'd0);
        tick();
        check("restart_rail", 32'(dbg_state), 32'd1);

        // power-up timeout
        do_reset();
        sys_req = 1'b1;
        tick();
        repeat (99) tick();
        check("timeout_not_yet", 32'(dbg_state), 32'd1);
        tick();
        check("timeout_state", 32'(dbg_state), 32'd5);
        check("timeout_fault", 32'(sys_fault), 32'd1);
        check("timeout_en", 32'(pwr_en), 32'd0);
        for (int i = 0; i < 20; i++) begin
            sys_req = 1'($urandom_range(0, 1));
            pwr_pok = 1'($urandom_range(0, 1));
            tick();
        end
        check("fault_sticky", 32'(sys_fault), 32'd1);
        do_reset();
        check("fault_cleared", 32'(sys_fault), 32'd0);

        // pok on the last allowed rail cycle beats the timeout
        sys_req = 1'b1;
        tick();
        repeat (99) tick();
        pwr_pok = 1'b1;
        tick();
        check("pok_beats_timeout", 32'(dbg_state), 32'd2);

        // pok loss while on
        do_reset();
        go_on();
        pwr_pok = 1'b0;
        tick();
        check("pok_loss_fault", 32'(dbg_state), 32'd5);

        // pok loss together with request drop: fault wins
        do_reset();
        go_on();
        pwr_pok = 1'b0;
        sys_req = 1'b0;
        tick();
        check("pok_loss_vs_drop", 32'(dbg_state), 32'd5);
        check("pok_loss_en", 32'(pwr_en), 32'd0);

        // PMIC error during VCOM settle
        do_reset();
        sys_req = 1'b1;
        pwr_pok = 1'b1;
        tick();
        tick();
        check("in_vcom_up", 32'(dbg_state), 32'd2);
        tick();
        pwr_error = 1'b1;
        tick();
        check("error_state", 32'(dbg_state), 32'd5);
        check("error_en_cen", {30'b0, pwr_en, pwr_cen}, 32'd0);
        pwr_error = 1'b0;

        // reset while on, then clean restart
        do_reset();
        go_on();
        rst_n = 1'b0;
        tick();
        check("rst_on_outputs", {27'b0, pwr_en, pwr_cen, sys_ready, sys_fault, |dbg_state}, 32'd0);
        rst_n = 1'b1;
        sys_req = 1'b1;
        pwr_pok = 1'b0;
        tick();
        check("rst_restart_state", 32'(dbg_state), 32'd1);
        check("rst_restart_en", 32'(pwr_en), 32'd1);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst_n = !((m_phase == 5 && $urandom_range(0, 19) == 0) || $urandom_range(0, 999) == 0);
            pwr_error = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) sys_req = ~sys_req;
            if ($urandom_range(0, 14) == 0) pwr_pok = ~pwr_pok;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/power_seq.md
POWER_SEQ -- requirements
Module: power_seq

Interface
REQ-001 SHALL have parameter PON_TIMEOUT, default 24'd8000000, max cycles in RAIL_UP waiting for pwr_pok (~240 ms at 33 MHz, covers two PMIC status polls).
REQ-002 SHALL have parameter VCOM_SETTLE, default 24'd330000, cycles held in VCOM_UP before sys_ready (~10 ms).
REQ-003 SHALL have parameter VCOM_OFF_DLY, default 24'd330000, cycles held in VCOM_DOWN before dropping pwr_en.
REQ-004 clk  input  1  system clock, 33 MHz.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 sys_req  input  1  level; display controller wants panel power.
REQ-007 sys_ready  output  1  rails and VCOM up and settled; updates may run.
REQ-008 sys_fault  output  1  sticky fault; power-up timed out, pok lost, or PMIC link error.
REQ-009 pwr_en  output  1  to PMIC controller en (main rails).
REQ-010 pwr_cen  output  1  to PMIC controller cen (VCOM).
REQ-011 pwr_pok  input  1  from PMIC controller; power-good, refreshed periodically.
REQ-012 pwr_error  input  1  from PMIC controller; I2C error, sticky upstream.
REQ-013 dbg_state  output  3  current state encoding.

Function
REQ-014 SHALL implement states OFF=0, RAIL_UP=1, VCOM_UP=2, ON=3, VCOM_DOWN=4, FAULT=5; all outputs registered.
REQ-015 Outputs per state: OFF en=0 cen=0; RAIL_UP en=1 cen=0; VCOM_UP en=1 cen=1; ON en=1 cen=1 ready=1; VCOM_DOWN en=1 cen=0; FAULT en=0 cen=0 fault=1.
REQ-016 OFF: sys_req=1 -> RAIL_UP next cycle, 24-bit counter cleared.
REQ-017 RAIL_UP: pwr_pok=1 -> VCOM_UP, counter cleared; counter reaching PON_TIMEOUT-1 without pok -> FAULT; sys_req=0 -> VCOM_DOWN.
REQ-018 VCOM_UP: counter reaching VCOM_SETTLE-1 -> ON; sys_req=0 -> VCOM_DOWN, counter cleared.
REQ-019 ON: sys_req=0 -> VCOM_DOWN, counter cleared; pwr_pok=0 -> FAULT.
REQ-020 VCOM_DOWN: counter reaching VCOM_OFF_DLY-1 -> OFF; sys_req re-asserted mid-delay SHALL NOT abort; delay completes, OFF then restarts on next cycle.
REQ-021 pwr_error=1 in any state SHALL force FAULT next cycle; highest priority over all other transitions.
REQ-022 pok lost and sys_req=0 in same ON cycle: FAULT wins.
REQ-023 pok arrival and timeout in same RAIL_UP cycle: pok wins.
REQ-024 FAULT SHALL be exited only by reset; sys_fault SHALL remain 1.
REQ-025 pwr_pok SHALL be ignored in OFF, VCOM_DOWN, FAULT.
REQ-026 Counter SHALL saturate, never wrap; compare widths 24 bit.
REQ-027 sys_ready SHALL deassert in the same cycle pwr_cen deasserts, never later.

Reset
REQ-028 On rst_n=0 at clk edge: state=OFF, counter=0, pwr_en=0, pwr_cen=0, sys_ready=0, sys_fault=0, dbg_state=0.
REQ-029 Reset mid-operation SHALL drop pwr_en and pwr_cen on the first reset edge with no down-sequence delay.

Structure
REQ-030 State encodings and default timing constants SHALL live in shared package caster_pwr_pkg, also used by the PMIC controller debug decode.
REQ-031 No sub-module; single FSM plus one counter in one module.
REQ-032 Instantiated directly upstream of the PMIC controller, pwr_en/pwr_cen/pwr_pok/pwr_error wired point-to-point.

Verification (bench parameters PON_TIMEOUT=100, VCOM_SETTLE=10, VCOM_OFF_DLY=10)
REQ-033 sys_req=1, pok=1 after 40 cycles -> en=1 next cycle, cen=1 one cycle after pok seen, sys_ready=1 exactly 10 cycles later.
REQ-034 sys_req=1, pok held 0 -> FAULT after 100 RAIL_UP cycles, en=0, sys_fault=1, holds until rst_n=0.
REQ-035 In ON, sys_req=0 -> cen=0 and ready=0 same cycle, en=0 after 10 cycles; sys_req=1 at cycle 5 of delay -> OFF reached, then RAIL_UP.
REQ-036 In ON, pok=0 for one cycle -> FAULT next cycle; simultaneous sys_req=0 still -> FAULT.
REQ-037 pwr_error=1 during VCOM_UP -> FAULT next cycle, en=cen=0.
REQ-038 rst_n=0 for one cycle while ON -> all outputs 0 next edge; rst_n=1 with sys_req=1 -> clean RAIL_UP restart.
